// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared FSM state type and width helpers for the adder BIST controller
package adder_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Vector index {a, b, cin} for N-bit operands
    function automatic int vec_width(input int n);
        return 2 * n + 1;
    endfunction

    // Error counter wide enough to count every vector without saturating
    function automatic int cnt_width(input int n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// rtl/adder_ref_model.sv - combinational golden N-bit a+b+cin producing {cout,sum}
module adder_ref_model #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N:0]   o_result
);

    // Operands are zero-extended so the carry-out lands in the top bit
    assign o_result = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive adder BIST engine; optional ADDER_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int N             = 2,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [N-1:0]   a,
    output logic [N-1:0]   b,
    output logic           cin,
    input  logic [N-1:0]   sum,
    input  logic           cout,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N+1:0] err_count,
    output logic [2*N:0]   first_fail_vec
);

    localparam int VW = vec_width(N);
    localparam int CW = cnt_width(N);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [VW-1:0] LAST_VEC    = '1;
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_t          r_state;
    logic [VW-1:0]   r_vec;
    logic [SW-1:0]   r_settle;
    logic [CW-1:0]   r_err;
    logic [VW-1:0]   r_ffv;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic [N:0]      w_ref;
    logic            w_mismatch;
    logic            w_stop;
    logic [CW-1:0]   w_err_inc;

    // The driven operands come straight from the vector register, so they
    // hold steady through DRIVE/CHECK and keep the last vector in DONE
    assign a   = r_vec[VW-1 -: N];
    assign b   = r_vec[N:1];
    assign cin = r_vec[0];

    adder_ref_model #(.N(N)) u_ref (
        .i_a      (a),
        .i_b      (b),
        .i_cin    (cin),
        .o_result (w_ref)
    );

    assign w_mismatch = (w_ref != {cout, sum});
    assign w_err_inc  = (r_err == CNT_MAX) ? r_err : r_err + CW'(1);

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;

    // Sweep FSM: load vector, let the adder settle, sample and score, advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_vec    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_ffv    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_DRIVE;
                        r_vec    <= '0;
                        r_settle <= SETTLE_LOAD;
                        r_err    <= '0;
                        r_ffv    <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (r_settle == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= w_err_inc;
                        if (r_err == '0) begin
                            r_ffv <= r_vec;
                        end
                    end
                    if ((r_vec == LAST_VEC) || w_stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_err == '0);
                    end else begin
                        r_state  <= S_DRIVE;
                        r_vec    <= r_vec + VW'(1);
                        r_settle <= SETTLE_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - directed self-checking bench for adder_bist_ctrl with N=2, SETTLE_CYCLES=4
module tb_adder_bist_ctrl;

    localparam int N = 2;
    localparam int S = 4;
    localparam int FULL_EDGES = 160;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    localparam int COUT_EDGES = 40;
    localparam int COUT_ERRS  = 1;
    localparam int SUM0_EDGES = 5;
    localparam int SUM0_ERRS  = 1;
`else
    localparam int COUT_EDGES = 160;
    localparam int COUT_ERRS  = 16;
    localparam int SUM0_EDGES = 160;
    localparam int SUM0_ERRS  = 16;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [N-1:0]   a, b, sum;
    logic           cin, cout, busy, done, pass;
    logic [2*N+1:0] err_count;
    logic [2*N:0]   first_fail_vec;

    // 0 = healthy adder, 1 = cout stuck at 0, 2 = sum[0] stuck at 1
    int             fault = 0;
    logic [N:0]     good;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign good = a + b + cin;
    assign sum  = (fault == 2) ? (good[N-1:0] | 2'b01) : good[N-1:0];
    assign cout = (fault == 1) ? 1'b0 : good[N];

    adder_bist_ctrl #(.N(N), .SETTLE_CYCLES(S)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .a              (a),
        .b              (b),
        .cin            (cin),
        .sum            (sum),
        .cout           (cout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_vec (first_fail_vec)
    );

    // Pulse start for edge 0, check the post-start state, then count edges until done
    task automatic run_sweep(input string name, input bit noise, output int edges);
        edges = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || err_count !== 0 || first_fail_vec !== 0 || {a, b, cin} !== 5'd0) begin
            bad++;
            $display("FAIL %s_start: busy=%b done=%b err=%0d ffv=%0d abc=%b, required busy=1 done=0 err=0 ffv=0 abc=0",
                     name, busy, done, err_count, first_fail_vec, {a, b, cin});
        end
        for (int e = 1; e <= 1000; e++) begin
            start = noise && (e == 20 || e == 90 || e == 159);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                edges = e;
                break;
            end
            if (!busy) begin
                bad++;
                total++;
                $display("FAIL %s_busy: busy dropped at edge %0d without done", name, e);
                break;
            end
        end
        total++;
        if (edges < 0) begin
            bad++;
            $display("FAIL %s_timeout: done not seen within bound", name);
        end
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input bit exp_pass, input int exp_err, input int exp_ffv);
        total++;
        if (edges != exp_edges) begin
            bad++;
            $display("FAIL %s_edges: got %0d required %0d", name, edges, exp_edges);
        end
        total++;
        if (pass !== exp_pass || busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL %s_flags: pass=%b busy=%b done=%b required pass=%b busy=0 done=1",
                     name, pass, busy, done, exp_pass);
        end
        total++;
        if (err_count !== exp_err[2*N+1:0]) begin
            bad++;
            $display("FAIL %s_err: got %0d required %0d", name, err_count, exp_err);
        end
        total++;
        if (first_fail_vec !== exp_ffv[2*N:0]) begin
            bad++;
            $display("FAIL %s_ffv: got %0d required %0d", name, first_fail_vec, exp_ffv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (busy !== 0 || done !== 0 || pass !== 0 || err_count !== 0 || first_fail_vec !== 0 || {a, b, cin} !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b pass=%b err=%0d ffv=%0d abc=%b, required all 0",
                     busy, done, pass, err_count, first_fail_vec, {a, b, cin});
        end
    endtask

    task automatic test_good_adder();
        int edges;
        fault = 0;
        run_sweep("good", 1'b0, edges);
        check_result("good", edges, FULL_EDGES, 1'b1, 0, 0);
        // last vector {3,3,1} is held in DONE
        total++;
        if ({a, b, cin} !== 5'b11111) begin
            bad++;
            $display("FAIL good_hold: abc=%b required 11111", {a, b, cin});
        end
    endtask

    task automatic test_cout_stuck();
        int edges;
        fault = 1;
        run_sweep("cout0", 1'b0, edges);
        check_result("cout0", edges, COUT_EDGES, 1'b0, COUT_ERRS, 7);
    endtask

    task automatic test_sum0_stuck();
        int edges;
        fault = 2;
        run_sweep("sum0", 1'b0, edges);
        check_result("sum0", edges, SUM0_EDGES, 1'b0, SUM0_ERRS, 0);
    endtask

    task automatic test_mid_reset();
        int edges;
        fault = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        total++;
        if (err_count === 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: err=%0d busy=%b, required err>0 busy=1", err_count, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 0 || done !== 0 || err_count !== 0 || first_fail_vec !== 0 || {a, b, cin} !== 5'd0) begin
            bad++;
            $display("FAIL midrst_post: busy=%b done=%b err=%0d ffv=%0d abc=%b, required all 0",
                     busy, done, err_count, first_fail_vec, {a, b, cin});
        end
        fault = 0;
        run_sweep("midrst_rerun", 1'b0, edges);
        check_result("midrst_rerun", edges, FULL_EDGES, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int edges;
        fault = 1;
        run_sweep("noise", 1'b1, edges);
        check_result("noise", edges, COUT_EDGES, 1'b0, COUT_ERRS, 7);
        // restart straight from DONE; run_sweep checks done dropped and counters cleared
        run_sweep("restart", 1'b0, edges);
        check_result("restart", edges, COUT_EDGES, 1'b0, COUT_ERRS, 7);
    endtask

    initial begin
        test_reset();
        test_good_adder();
        test_cout_stuck();
        test_sum0_stuck();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_bist_ctrl.md
# adder_bist_ctrl

Self-checking stimulus and response engine for the NOR-gate ripple-carry adder (`adder1_use` family). It owns the adder's inputs and reads back its sum and carry. It sweeps every operand/carry combination exhaustively, waits a programmable settle time per vector, compares against a golden model, and reports pass/fail, error count and the first failing vector. It is a synthesizable, on-chip replacement for hand-written adder stimulus sequences.

## Interface
Parameters:
- `N`, 2, operand width in bits.
- `SETTLE_CYCLES`, 100, cycles each vector is held before sampling (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE.
- `a`  out  N  operand A to adder under test.
- `b`  out  N  operand B to adder under test.
- `cin`  out  1  carry-in to adder under test.
- `sum`  in  N  adder sum.
- `cout`  in  1  adder carry-out.
- `busy`  out  1  high in DRIVE/CHECK.
- `done`  out  1  high in DONE, held until restart or reset.
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0.
- `err_count`  out  2N+2  number of mismatching vectors, saturating.
- `first_fail_vec`  out  2N+1  index of first mismatching vector, {a,b,cin}; 0 if none.

## Operation
- Vector index `v` is 2N+1 bits, decoded as {a, b, cin}, swept from 0 to 2^(2N+1)−1.
- Expected result is a+b+cin, (N+1)-bit, compared against {cout,sum}.
- FSM states are IDLE, DRIVE, CHECK, DONE.
  - IDLE: `start` → DRIVE, with `v`=0, `err_count`=0, `first_fail_vec`=0.
  - DRIVE: `a`/`b`/`cin` registered from `v`. Settle counter runs SETTLE_CYCLES−1 down to 0; at 0 → CHECK.
  - CHECK: one cycle. Compare. On mismatch: increment `err_count`, saturating at all-ones. If this is the first mismatch, latch `first_fail_vec`=v. Then, if v is the last vector → DONE; otherwise increment v → DRIVE.
  - DONE: `done`=1 and `pass` valid. `start` → restart exactly as from IDLE.
- `start` in DRIVE/CHECK is ignored.
- Outputs `a`/`b`/`cin` are registered and hold the current vector through DRIVE and CHECK. They hold the last vector in DONE.
- Reset values: all outputs 0, state IDLE. Reset asserted mid-sweep aborts on the next edge with no partial result retained.

## Timing
- Each vector occupies SETTLE_CYCLES+1 cycles.
- Edge 0 is the edge that samples `start`. Vector 0 appears on `a`/`b`/`cin` after edge 0.
- `done` rises after edge 2^(2N+1)·(SETTLE_CYCLES+1).
- `sum`/`cout` are sampled on the CHECK-cycle edge only. The adder path must settle within SETTLE_CYCLES clocks.
- `busy` and `done` are never high together. `busy` falls on the same edge `done` rises.

## Configuration
- `ADDER_BIST_STOP_ON_FAIL_EN` defined: the first mismatch in CHECK transitions straight to DONE, giving `err_count`=1, `pass`=0, and `first_fail_vec` latched.
- Undefined (default): the full sweep always completes and every mismatch is counted.

## Structure
- Package `adder_bist_pkg`:
  - FSM state enum.
  - Width helpers: vector width 2N+1, count width 2N+2.
- Sub-module `adder_ref_model`: combinational golden N-bit a+b+cin → {cout,sum}. It is instantiated once and compared in CHECK.

## Test plan
All scenarios use N=2 and SETTLE_CYCLES=4; 32 vectors.

1. Correct NOR adder connected, pulse `start` → `done` after edge 160, `pass`=1, `err_count`=0, `first_fail_vec`=0.
2. `cout` forced 0 → `err_count`=16, `first_fail_vec`=7 (a=0, b=3, cin=1), `pass`=0.
3. Same fault with `ADDER_BIST_STOP_ON_FAIL_EN` → `done` after edge 40, `err_count`=1, `first_fail_vec`=7.
4. `sum[0]` forced 1 → `err_count`=16, `first_fail_vec`=0.
5. `rst` pulsed at cycle 50 of a sweep → next edge: `busy`=0, `done`=0, `a`=`b`=`cin`=0, `err_count`=0. A subsequent `start` runs the full 160 cycles.
6. Extra `start` pulses during `busy` → no effect on timing or result. `start` in DONE → `done` drops next edge, counters cleared, and the sweep repeats with identical results.
